// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: multiplexes NUM_DIGITS hex digits onto one shared ssdec and a
// common-segment display. A shadow digit bank is loaded by the host and committed
// to the active bank only in IDLE or at a frame boundary, so a frame never tears.
// Each digit is preceded by BLANK_CYCLES of dead time with all commons off.
// Optional feature macro: SSD_LZ_BLANK_EN (leading-zero suppression).
module ssd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    scan_en,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_pending,
    output logic [3:0]              dec_in,
    output logic                    dec_enable,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);

    localparam int unsigned DATA_W     = 4 * NUM_DIGITS;
    localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES
                                                                       : BLANK_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    // BLANK_LAST is never compared when BLANK_CYCLES is 0 (BLANK is unreachable).
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1)
                                                                 : '0;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } state_e;

    // State entered before every digit: dead time if configured, else straight to SHOW.
    localparam state_e GAP_STATE = (BLANK_CYCLES > 0) ? StBlank : StShow;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   active_q, active_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                pending_q, pending_d;
    logic [3:0]          dec_in_q, dec_in_d;
    logic                dec_en_q, dec_en_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                frame_done_q, frame_done_d;

    logic                frame_end;
    logic                commit;
    logic [3:0]          nibble;

`ifdef SSD_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_from;  // bit i: nibble i and all higher nibbles are 0
    logic                  zero_run;
`endif

    // Scan sequencer: next state, digit index and cycle counter.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        if (!scan_en) begin
            // Abort from any state; a partial frame never reports frame_done.
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = GAP_STATE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                StBlank: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = StShow;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StShow: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = GAP_STATE;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Digit banks: commits take the pre-write shadow, so a write landing on a
    // commit cycle stays pending for the next boundary.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        commit    = pending_q && ((state_q == StIdle) || frame_end);
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (wr_en) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end
    end

    // Nibble of the digit that will be current in the next cycle.
    always_comb begin
        nibble = 4'h0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                nibble = active_d[4*i +: 4];
            end
        end
    end

`ifdef SSD_LZ_BLANK_EN
    // Leading-zero map over the bank that will be active next cycle.
    always_comb begin
        zero_from = '0;
        zero_run  = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run     = zero_run & (active_d[4*i +: 4] == 4'h0);
            zero_from[i] = zero_run;
        end
    end
`endif

    // Output decode from next-state values so every output is a plain register.
    always_comb begin
        sel_d        = '0;
        dec_en_d     = 1'b0;
        dec_in_d     = 4'h0;
        frame_done_d = frame_end;
        case (state_d)
            StBlank: begin
                dec_in_d = nibble;
            end
            StShow: begin
                sel_d    = NUM_DIGITS'(1) << idx_d;
                dec_in_d = nibble;
`ifdef SSD_LZ_BLANK_EN
                // Common stays selected so dwell timing is unchanged; digit 0 always shows.
                dec_en_d = !((idx_d != '0) && zero_from[idx_d]);
`else
                dec_en_d = 1'b1;
`endif
            end
            default: begin
                sel_d    = '0;
                dec_en_d = 1'b0;
                dec_in_d = 4'h0;
            end
        endcase
    end

    // State, banks and registered outputs; reset drops any pending write.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            dec_in_q     <= 4'h0;
            dec_en_q     <= 1'b0;
            sel_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            dec_in_q     <= dec_in_d;
            dec_en_q     <= dec_en_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_pending = pending_q;
    assign dec_in     = dec_in_q;
    assign dec_enable = dec_en_q;
    assign digit_sel  = sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2.
// Define SSD_LZ_BLANK_EN on both RTL and bench to exercise leading-zero suppression.
module tb_ssd_scan_ctrl;

    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DW + BC;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          scan_en = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = 16'h0;
    logic          wr_pending;
    logic [3:0]    dec_in;
    logic          dec_enable;
    logic [ND-1:0] digit_sel;
    logic          frame_done;

    int errors = 0;
    int checks = 0;

    ssd_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .scan_en   (scan_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_pending(wr_pending),
        .dec_in    (dec_in),
        .dec_enable(dec_enable),
        .digit_sel (digit_sel),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected dec_enable for digit d of a SHOW slot.
    function automatic logic exp_en(input logic [15:0] data, input int d);
        logic lz;
        lz = 1'b0;
`ifdef SSD_LZ_BLANK_EN
        lz = 1'b1;
`endif
        return !(lz && d > 0 && (data >> (4 * d)) == 16'h0);
    endfunction

    task automatic check_dark(input string tag);
        check_eq({tag, " sel"}, 32'(digit_sel), 32'h0);
        check_eq({tag, " en"}, 32'(dec_enable), 32'h0);
        check_eq({tag, " fd"}, 32'(frame_done), 32'h0);
    endtask

    // Walks n cycles of a frame from its first BLANK cycle, with up to two host
    // writes injected at frame positions wa and wb (-1 = none).
    task automatic check_frame(input string name, input logic [15:0] data, input logic fd0,
                               input logic pend0, input int wa, input logic [15:0] va,
                               input int wb, input logic [15:0] vb, input int n);
        logic pend;
        pend = pend0;
        for (int p = 0; p < n; p++) begin
            int   d;
            int   ph;
            logic show;
            d    = p / SLOT;
            ph   = p % SLOT;
            show = (ph >= BC);
            check_eq($sformatf("%s p%0d sel", name, p), 32'(digit_sel),
                     show ? (32'h1 << d) : 32'h0);
            check_eq($sformatf("%s p%0d en", name, p), 32'(dec_enable),
                     32'(show && exp_en(data, d)));
            check_eq($sformatf("%s p%0d din", name, p), 32'(dec_in), 32'(data[4*d +: 4]));
            check_eq($sformatf("%s p%0d fd", name, p), 32'(frame_done),
                     32'((p == 0) ? fd0 : 1'b0));
            check_eq($sformatf("%s p%0d pend", name, p), 32'(wr_pending), 32'(pend));
            if (p == wa) begin
                wr_en   = 1'b1;
                wr_data = va;
                pend    = 1'b1;
            end else if (p == wb) begin
                wr_en   = 1'b1;
                wr_data = vb;
                pend    = 1'b1;
            end
            step();
            wr_en = 1'b0;
        end
    endtask

    // Stops scanning, loads data through IDLE and restarts at frame position 0.
    task automatic load_idle(input string name, input logic [15:0] data);
        scan_en = 1'b0;
        wr_en   = 1'b1;
        wr_data = data;
        step();
        wr_en = 1'b0;
        check_eq({name, " pend set"}, 32'(wr_pending), 32'h1);
        step();
        check_eq({name, " pend commit"}, 32'(wr_pending), 32'h0);
        check_dark({name, " idle"});
        scan_en = 1'b1;
        step();
    endtask

    initial begin
        // Reset state and idle after release.
        repeat (3) @(posedge clk);
        #1;
        check_dark("rst");
        check_eq("rst din", 32'(dec_in), 32'h0);
        check_eq("rst pend", 32'(wr_pending), 32'h0);
        n_rst = 1'b1;
        step();
        step();
        check_dark("idle");
        check_eq("idle din", 32'(dec_in), 32'h0);
        check_eq("idle pend", 32'(wr_pending), 32'h0);

        // Load 1234 in IDLE, commit as scanning starts.
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        check_eq("wr pend", 32'(wr_pending), 32'h1);
        check_dark("wr idle");
        scan_en = 1'b1;
        step();
        check_frame("f1", 16'h1234, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);

        // Mid-frame write: current frame untouched, next frame shows it.
        check_frame("f2", 16'h1234, 1'b1, 1'b0, 3, 16'hABCD, -1, 16'h0, FRAME);

        // Write 9876 mid-frame, then 5555 on the commit cycle.
        check_frame("f3", 16'hABCD, 1'b1, 1'b0, 5, 16'h9876, FRAME - 1, 16'h5555, FRAME);
        check_frame("f4", 16'h9876, 1'b1, 1'b1, -1, 16'h0, -1, 16'h0, FRAME);
        check_frame("f5", 16'h5555, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);

        // Abort while digit 2 is lit.
        check_frame("f6", 16'h5555, 1'b1, 1'b0, -1, 16'h0, -1, 16'h0, 2 * SLOT + BC + 1);
        check_eq("abort pre sel", 32'(digit_sel), 32'h4);
        scan_en = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            check_dark($sformatf("abort c%0d", i));
            step();
        end
        scan_en = 1'b1;
        step();
        check_frame("f7", 16'h5555, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);

        // Leading-zero patterns (all digits enabled when suppression is not built).
        load_idle("lz70", 16'h0070);
        check_frame("lz70", 16'h0070, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);
        load_idle("lz00", 16'h0000);
        check_frame("lz00", 16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);

        // Async reset mid-scan with a write pending.
        wr_en   = 1'b1;
        wr_data = 16'h4321;
        step();
        wr_en = 1'b0;
        step();
        step();
        check_eq("pre rst sel", 32'(digit_sel), 32'h1);
        check_eq("pre rst pend", 32'(wr_pending), 32'h1);
        #3;
        n_rst = 1'b0;
        #1;
        check_dark("async rst");
        check_eq("async rst din", 32'(dec_in), 32'h0);
        check_eq("async rst pend", 32'(wr_pending), 32'h0);
        scan_en = 1'b0;
        #2;
        n_rst = 1'b1;
        step();
        step();
        check_eq("post rst pend", 32'(wr_pending), 32'h0);
        scan_en = 1'b1;
        step();
        check_frame("post rst", 16'h0000, 1'b0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
